// File: rtl/wb_stage_if.sv
// MEM -> WB pipeline bus: one retiring instruction plus its commit side-info.
interface wb_stage_if;
  logic        mem_to_wb_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic [31:0] mem_inst;
  logic        mem_gr_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata;
  logic        mem_csr_re;
  logic        mem_csr_we;
  logic [13:0] mem_csr_num;
  logic [31:0] mem_csr_wmask;
  logic [31:0] mem_csr_wvalue;
  logic [2:0]  mem_tlb_op;
  logic        mem_excp;
  logic [5:0]  mem_ecode;
  logic [8:0]  mem_esubcode;
  logic [31:0] mem_badv;
  logic        mem_ertn;

  modport master (
    output mem_to_wb_valid, mem_pc, mem_inst, mem_gr_we, mem_rf_waddr, mem_rf_wdata,
           mem_csr_re, mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wvalue,
           mem_tlb_op, mem_excp, mem_ecode, mem_esubcode, mem_badv, mem_ertn,
    input  wb_allowin
  );

  modport slave (
    input  mem_to_wb_valid, mem_pc, mem_inst, mem_gr_we, mem_rf_waddr, mem_rf_wdata,
           mem_csr_re, mem_csr_we, mem_csr_num, mem_csr_wmask, mem_csr_wvalue,
           mem_tlb_op, mem_excp, mem_ecode, mem_esubcode, mem_badv, mem_ertn,
    output wb_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// LoongArch write-back / commit stage: GPR/CSR writes, TLB commands, exception/ERTN
// entry, pipeline flush and debug trace. TLB ops spend a second cycle as a refetch flush.
module wb_stage #(
  parameter int TLBNUM = 16,
  localparam int IDXW  = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  wb_stage_if.slave        mem,
  input  logic [31:0]      csr_rvalue,
  output logic             csr_re,
  output logic [13:0]      csr_num,
  output logic             csr_we,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             tlbrd_en,
  output logic             tlbwr_en,
  output logic             tlbfill_en,
  output logic [IDXW-1:0]  tlb_windex,
  output logic             excp_commit,
  output logic             ertn_commit,
  output logic [5:0]       excp_ecode,
  output logic [8:0]       excp_esubcode,
  output logic [31:0]      excp_pc,
  output logic [31:0]      excp_badv,
  output logic             flush,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  typedef enum logic [1:0] {EMPTY, COMMIT, TLB2} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [2:0]  tlb_op;   // {fill, wr, rd}
    logic        excp;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badv;
    logic        ertn;
  } wb_hold_t;

  state_e          state_q, state_d;
  wb_hold_t        hold_q, hold_d;
  logic [IDXW-1:0] windex_q, windex_d;

  logic in_commit, in_tlb2, tlb_any, plain, allowin, load;

  assign in_commit = (state_q == COMMIT);
  assign in_tlb2   = (state_q == TLB2);
  assign tlb_any   = |hold_q.tlb_op;
  // A "plain" commit is one that is allowed to have architectural side effects.
  assign plain     = in_commit & ~hold_q.excp & ~hold_q.ertn;
  assign allowin   = (state_q == EMPTY) | (plain & ~tlb_any);
  assign load      = mem.mem_to_wb_valid & allowin;

  assign mem.wb_allowin = allowin;

  always_comb begin
    hold_d  = hold_q;
    state_d = state_q;
    if (load) begin
      hold_d = '{pc:         mem.mem_pc,
                 gr_we:      mem.mem_gr_we,
                 waddr:      mem.mem_rf_waddr,
                 wdata:      mem.mem_rf_wdata,
                 csr_re:     mem.mem_csr_re,
                 csr_we:     mem.mem_csr_we,
                 csr_num:    mem.mem_csr_num,
                 csr_wmask:  mem.mem_csr_wmask,
                 csr_wvalue: mem.mem_csr_wvalue,
                 tlb_op:     mem.mem_tlb_op,
                 excp:       mem.mem_excp,
                 ecode:      mem.mem_ecode,
                 esubcode:   mem.mem_esubcode,
                 badv:       mem.mem_badv,
                 ertn:       mem.mem_ertn};
      state_d = COMMIT;
    end else begin
      unique case (state_q)
        COMMIT:  state_d = (plain & tlb_any) ? TLB2 : EMPTY;
        TLB2:    state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    windex_d = windex_q;
    if (tlbfill_en)
      windex_d = (windex_q == IDXW'(TLBNUM - 1)) ? '0 : windex_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= EMPTY;
      hold_q   <= '0;
      windex_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      windex_q <= windex_d;
    end
  end

  assign csr_re     = plain & hold_q.csr_re;
  assign csr_num    = hold_q.csr_num;
  assign csr_we     = plain & hold_q.csr_we;
  assign csr_wmask  = hold_q.csr_wmask;
  assign csr_wvalue = hold_q.csr_wvalue;

  assign rf_we    = plain & hold_q.gr_we & (hold_q.waddr != 5'd0);
  assign rf_waddr = hold_q.waddr;
  assign rf_wdata = csr_re ? csr_rvalue : hold_q.wdata;

  assign tlbrd_en   = plain & hold_q.tlb_op[0];
  assign tlbwr_en   = plain & hold_q.tlb_op[1];
  assign tlbfill_en = plain & hold_q.tlb_op[2];
  assign tlb_windex = windex_q;

  assign excp_commit   = in_commit & hold_q.excp;
  assign ertn_commit   = in_commit & hold_q.ertn & ~hold_q.excp;
  assign excp_ecode    = hold_q.ecode;
  assign excp_esubcode = hold_q.esubcode;
  // Also valid in TLB2: the refetch target is derived from it.
  assign excp_pc       = hold_q.pc;
  assign excp_badv     = hold_q.badv;
  assign flush         = excp_commit | ertn_commit | in_tlb2;

  assign fwd_valid = in_commit & rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;

  assign debug_wb_pc       = hold_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed + random bench for wb_stage against a transaction-level commit model.
module tb_wb_stage;
  localparam int TLBNUM = 4;
  localparam int IDXW   = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  wb_stage_if mif();
  logic [31:0]     csr_rvalue;
  logic            csr_re, csr_we, rf_we, tlbrd_en, tlbwr_en, tlbfill_en;
  logic [13:0]     csr_num;
  logic [31:0]     csr_wmask, csr_wvalue, rf_wdata, excp_pc, excp_badv, fwd_data;
  logic [4:0]      rf_waddr, fwd_addr, debug_wb_rf_wnum;
  logic [IDXW-1:0] tlb_windex;
  logic            excp_commit, ertn_commit, flush, fwd_valid;
  logic [5:0]      excp_ecode;
  logic [8:0]      excp_esubcode;
  logic [31:0]     debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]      debug_wb_rf_we;

  wb_stage #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .mem(mif), .csr_rvalue(csr_rvalue),
    .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .tlbrd_en(tlbrd_en), .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en),
    .tlb_windex(tlb_windex), .excp_commit(excp_commit), .ertn_commit(ertn_commit),
    .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode), .excp_pc(excp_pc),
    .excp_badv(excp_badv), .flush(flush), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [2:0]  tlb;
    logic        excp;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] badv;
    logic        ertn;
    logic [31:0] rvalue;
  } ins_t;

  int total = 0;
  int bad   = 0;

  // Model: instruction committing this cycle, instruction in its refetch cycle, fill count.
  ins_t cur, tail;
  bit   cur_v, tail_v;
  int   fills;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ins_t gpr(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    ins_t r = '0;
    r.pc = pc; r.gr_we = 1'b1; r.waddr = a; r.wdata = d;
    return r;
  endfunction

  function automatic ins_t rnd();
    ins_t r = '0;
    r.pc     = $urandom & 32'hFFFF_FFFC;
    r.gr_we  = 1'($urandom_range(0, 1));
    r.waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    r.wdata  = $urandom;
    r.csr_re = ($urandom_range(0, 3) == 0);
    r.csr_we = ($urandom_range(0, 3) == 0);
    r.csr_num = 14'($urandom);
    r.wmask  = $urandom;
    r.wvalue = $urandom;
    r.tlb    = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
    r.excp   = ($urandom_range(0, 7) == 0);
    r.ecode  = 6'($urandom);
    r.esub   = 9'($urandom);
    r.badv   = $urandom;
    r.ertn   = (r.tlb == 3'b000) && ($urandom_range(0, 9) == 0);
    r.rvalue = $urandom;
    return r;
  endfunction

  task automatic drive(input bit v, input ins_t i);
    mif.mem_to_wb_valid = v;
    mif.mem_pc          = i.pc;
    mif.mem_inst        = ~i.pc;
    mif.mem_gr_we       = i.gr_we;
    mif.mem_rf_waddr    = i.waddr;
    mif.mem_rf_wdata    = i.wdata;
    mif.mem_csr_re      = i.csr_re;
    mif.mem_csr_we      = i.csr_we;
    mif.mem_csr_num     = i.csr_num;
    mif.mem_csr_wmask   = i.wmask;
    mif.mem_csr_wvalue  = i.wvalue;
    mif.mem_tlb_op      = i.tlb;
    mif.mem_excp        = i.excp;
    mif.mem_ecode       = i.ecode;
    mif.mem_esubcode    = i.esub;
    mif.mem_badv        = i.badv;
    mif.mem_ertn        = i.ertn;
    csr_rvalue          = i.rvalue;
  endtask

  function automatic bit normal(input bit v, input ins_t i);
    return v && !i.excp && !i.ertn;
  endfunction

  task automatic check_model();
    bit          nrm, we, cwe;
    logic [31:0] wd;
    nrm = normal(cur_v, cur);
    we  = nrm && cur.gr_we && (cur.waddr != 5'd0);
    cwe = nrm && cur.csr_we;
    wd  = cur.csr_re ? cur.rvalue : cur.wdata;
    chk("allowin", 32'(mif.wb_allowin), 32'((!cur_v && !tail_v) || (nrm && cur.tlb == 3'b000)));
    chk("flush", 32'(flush), 32'((cur_v && (cur.excp || cur.ertn)) || tail_v));
    chk("excp_commit", 32'(excp_commit), 32'(cur_v && cur.excp));
    chk("ertn_commit", 32'(ertn_commit), 32'(cur_v && cur.ertn && !cur.excp));
    chk("rf_we", 32'(rf_we), 32'(we));
    chk("fwd_valid", 32'(fwd_valid), 32'(we));
    chk("dbg_rf_we", 32'(debug_wb_rf_we), 32'({4{we}}));
    chk("csr_we", 32'(csr_we), 32'(cwe));
    chk("tlb_en", 32'({tlbfill_en, tlbwr_en, tlbrd_en}), 32'(nrm ? cur.tlb : 3'b000));
    chk("tlb_windex", 32'(tlb_windex), 32'(fills % TLBNUM));
    if (we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(cur.waddr));
      chk("rf_wdata", rf_wdata, wd);
      chk("fwd_addr", 32'(fwd_addr), 32'(cur.waddr));
      chk("fwd_data", fwd_data, wd);
      chk("dbg_wdata", debug_wb_rf_wdata, wd);
      chk("dbg_pc", debug_wb_pc, cur.pc);
    end
    if (cwe) begin
      chk("csr_wnum", 32'(csr_num), 32'(cur.csr_num));
      chk("csr_wmask", csr_wmask, cur.wmask);
      chk("csr_wvalue", csr_wvalue, cur.wvalue);
    end
    if (nrm && cur.csr_re) begin
      chk("csr_re", 32'(csr_re), 32'd1);
      chk("csr_rnum", 32'(csr_num), 32'(cur.csr_num));
    end
    if (cur_v && cur.excp) begin
      chk("excp_ecode", 32'(excp_ecode), 32'(cur.ecode));
      chk("excp_esub", 32'(excp_esubcode), 32'(cur.esub));
      chk("excp_badv", excp_badv, cur.badv);
      chk("excp_pc", excp_pc, cur.pc);
    end
    if (tail_v) chk("refetch_pc", excp_pc, tail.pc);
  endtask

  // One cycle: check outputs at negedge, offer the next instruction, advance the model.
  task automatic cyc(input bit v, input ins_t i);
    bit nrm, allow;
    @(negedge clk);
    check_model();
    drive(v, i);
    @(posedge clk);
    nrm   = normal(cur_v, cur);
    allow = (!cur_v && !tail_v) || (nrm && cur.tlb == 3'b000);
    if (nrm && cur.tlb[2]) fills++;
    tail_v = nrm && (cur.tlb != 3'b000);
    tail   = cur;
    cur_v  = v && allow;
    if (cur_v) cur = i;
  endtask

  initial begin
    ins_t i;
    cur = '0; tail = '0; cur_v = 0; tail_v = 0; fills = 0;
    resetn = 1'b0;
    drive(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", 32'(mif.wb_allowin), 32'd1);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_excp", 32'(excp_commit), 32'd0);
    chk("rst_windex", 32'(tlb_windex), 32'd0);
    chk("rst_dbg_pc", debug_wb_pc, 32'd0);
    chk("rst_csr_re", 32'(csr_re), 32'd0);
    chk("rst_fwd", 32'(fwd_valid), 32'd0);
    resetn = 1'b1;

    // back-to-back GPR writes, then r0 write
    cyc(1'b1, gpr(32'h1c00_0000, 5'd5, 32'h11));
    cyc(1'b1, gpr(32'h1c00_0004, 5'd6, 32'h22));
    cyc(1'b1, gpr(32'h1c00_0008, 5'd0, 32'h33));
    cyc(1'b0, '0);

    // csrrd
    i = gpr(32'h1c00_0010, 5'd7, 32'h0);
    i.csr_re = 1'b1; i.csr_num = 14'h005; i.rvalue = 32'hDEAD_BEEF;
    cyc(1'b1, i);
    cyc(1'b0, '0);

    // exception wins over gr_we/csr/tlb
    i = gpr(32'h1c00_0020, 5'd9, 32'h55);
    i.excp = 1'b1; i.ecode = 6'h0B; i.badv = 32'h1000; i.csr_we = 1'b1; i.tlb = 3'b100;
    cyc(1'b1, i);
    cyc(1'b1, gpr(32'h1c00_0024, 5'd1, 32'h77));  // offered during flush: dropped
    cyc(1'b0, '0);

    // six fills: index walks 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      i = '0; i.pc = 32'h1c00_1000 + 32'(k * 4); i.tlb = 3'b100;
      cyc(1'b1, i);
      cyc(1'b0, '0);
      cyc(1'b1, gpr(32'h1c00_2000, 5'd2, 32'h9));  // offered during refetch flush
    end
    cyc(1'b0, '0);

    // ertn
    i = gpr(32'h1c00_3000, 5'd3, 32'h1); i.ertn = 1'b1;
    cyc(1'b1, i);
    cyc(1'b0, '0);

    // async reset during the refetch cycle of a tlbwr
    i = '0; i.pc = 32'h1c00_4000; i.tlb = 3'b010;
    cyc(1'b1, i);
    cyc(1'b0, '0);
    @(negedge clk);
    check_model();
    resetn = 1'b0;
    #1;
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_allowin", 32'(mif.wb_allowin), 32'd1);
    chk("midrst_tlb", 32'({tlbfill_en, tlbwr_en, tlbrd_en}), 32'd0);
    chk("midrst_windex", 32'(tlb_windex), 32'd0);
    cur_v = 0; tail_v = 0; fills = 0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    for (int k = 0; k < 400; k++) cyc(($urandom_range(0, 3) != 0), rnd());
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
